// File: rtl/replicacao_pixel.sv
// replicacao_pixel: zoom-in by pixel replication, streaming a source ROM into a destination RAM.
// Each source pixel costs two ROM wait cycles plus one write per replicated destination pixel.
module replicacao_pixel #(
   parameter int LARGURA_ORIG = 160,
   parameter int ALTURA_ORIG  = 120
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  zoom_select,
   input  logic [7:0]  pixel_in,
   output logic [14:0] rom_addr,
   output logic [18:0] ram_addr,
   output logic [7:0]  pixel_out,
   output logic        wren,
   output logic        busy,
   output logic        done
);
   localparam int CW = LARGURA_ORIG > 1 ? $clog2(LARGURA_ORIG) : 1;
   localparam int RW = ALTURA_ORIG > 1 ? $clog2(ALTURA_ORIG) : 1;
   typedef enum logic [1:0] {IDLE, ESPERA, ESCRITA, FINAL} state_t;
   state_t state;
   logic [1:0] lg, dx, dy, em;
   logic [CW-1:0] c;
   logic [RW-1:0] r;
   logic w, last_col, last_pix;
   // escala is always a power of two, so it is held as its log2
   assign em = 2'((3'd1 << lg) - 3'd1);
   assign last_col = c == CW'(LARGURA_ORIG - 1);
   assign last_pix = last_col && r == RW'(ALTURA_ORIG - 1);
   function automatic logic [18:0] addr(input logic [RW-1:0] rr, input logic [CW-1:0] cc,
                                        input logic [1:0] yy, input logic [1:0] sh);
      return ((19'(rr) << sh) + 19'(yy)) * (19'(LARGURA_ORIG) << sh) + (19'(cc) << sh);
   endfunction
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         rom_addr  <= '0;
         ram_addr  <= '0;
         pixel_out <= '0;
         wren      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         lg        <= '0;
         r         <= '0;
         c         <= '0;
         dx        <= '0;
         dy        <= '0;
         w         <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               wren <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  lg       <= zoom_select[1] ? 2'd2 : {1'b0, zoom_select[0]};
                  r        <= '0;
                  c        <= '0;
                  dx       <= '0;
                  dy       <= '0;
                  w        <= 1'b0;
                  rom_addr <= '0;
                  done     <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ESPERA;
               end
            end
            ESPERA: begin
               w <= ~w;
               if (w) begin
                  pixel_out <= pixel_in;
                  ram_addr  <= addr(r, c, 2'd0, lg);
                  wren      <= 1'b1;
                  state     <= ESCRITA;
               end
            end
            ESCRITA: begin
               if (dx != em) begin
                  dx       <= dx + 2'd1;
                  ram_addr <= ram_addr + 19'd1;
               end else if (dy != em) begin
                  dx       <= '0;
                  dy       <= dy + 2'd1;
                  ram_addr <= addr(r, c, dy + 2'd1, lg);
               end else begin
                  dx   <= '0;
                  dy   <= '0;
                  wren <= 1'b0;
                  if (last_pix) state <= FINAL;
                  else begin
                     state    <= ESPERA;
                     rom_addr <= rom_addr + 15'd1;
                     c        <= last_col ? '0 : c + CW'(1);
                     r        <= last_col ? r + RW'(1) : r;
                  end
               end
            end
            FINAL: begin
               wren  <= 1'b0;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
